lpc_periph: RTL
===============

LPC_PERIPH -- requirements
Module: lpc_periph

Interface
REQ-001 SHALL have parameter IO_BASE, default 16'h0080, IO-cycle base address.
REQ-002 SHALL have parameter IO_MASK, default 16'hFFFF, address bits compared for IO cycles.
REQ-003 SHALL have parameter TPM_EN, default 1, enables TPM-locality (START=0101) cycle decoding.
REQ-004 SHALL have parameter TPM_BASE, default 16'hD400, and TPM_MASK, default 16'hF000, for TPM-cycle address match.
REQ-005 SHALL have parameter MAX_WAIT, default 8, maximum long-wait SYNC nibbles before error SYNC.
REQ-006 Clock and reset are fixed: one clock; reset is asynchronous and active-high.
REQ-007 clk_i  in  1  LPC clock (LCLK), all logic on rising edge.
REQ-008 rst_i  in  1  asynchronous, active-high reset.
REQ-009 lframe_i  in  1  LFRAME#, active low.
REQ-010 lad_i  in  4  LAD[3:0] sampled value.
REQ-011 lad_o  out  4  LAD value to drive.
REQ-012 lad_oe_o  out  1  LAD output enable (top level builds tristate).
REQ-013 addr_o  out  16  decoded cycle address.
REQ-014 data_o  out  8  write data from host.
REQ-015 wr_stb_o / rd_stb_o  out  1 each  one-cycle request pulses.
REQ-016 tpm_cycle_o  out  1  current/last request is a TPM-locality cycle.
REQ-017 data_i  in  8  read data; ack_i  in  1  request complete, sampled only in SYNC.

Function
REQ-018 States SHALL be IDLE, CYCTYPE, ADDR, DATA_WR, TAR_H, SYNC, DATA_RD, TAR_P, IGNORE.
REQ-019 From any state, lframe_i=0 with lad_i=0000 (or 0101 when TPM_EN=1) SHALL load CYCTYPE next, set tpm_cycle_o accordingly, drop lad_oe_o; consecutive START clocks keep the last one.
REQ-020 From any state, lframe_i=0 with any other lad_i (incl. abort 1111) SHALL go IDLE with lad_oe_o=0 next cycle.
REQ-021 CYCTYPE: lad_i 0000 = read, 0010 = write -> ADDR; any other value -> IGNORE.
REQ-022 ADDR SHALL capture 4 nibbles MSB first into addr_o, then match (addr & MASK)==(BASE & MASK) against IO or TPM set; miss -> IGNORE; hit read -> TAR_H; hit write -> DATA_WR.
REQ-023 DATA_WR SHALL capture 2 nibbles, low nibble first, into data_o, then TAR_H.
REQ-024 TAR_H SHALL last 2 clocks with lad_oe_o=0, then SYNC.
REQ-025 On entry to SYNC, exactly one of wr_stb_o/rd_stb_o SHALL pulse high for the first SYNC clock.
REQ-026 In SYNC, lad_oe_o=1; drive 0110 each clock until ack_i=1 is sampled, then next nibble 0000 (ready); ack_i in first SYNC clock yields 0000 as first driven nibble.
REQ-027 If MAX_WAIT long-wait nibbles were driven without ack, drive 1010 (error) once and ignore later ack_i.
REQ-028 After ready/error SYNC: write -> TAR_P; read -> DATA_RD driving data_i (latched at ack) low nibble then high; on error drive FF.
REQ-029 TAR_P SHALL drive 1111 for 1 clock, then release (lad_oe_o=0) for 1 clock, then IDLE.
REQ-030 IGNORE SHALL never drive LAD and exit only via REQ-019/020.
REQ-031 lad_o/lad_oe_o SHALL be registered; lad_oe_o=1 only in SYNC, DATA_RD, first TAR_P clock.

Reset
REQ-032 rst_i SHALL force IDLE, lad_oe_o=0, lad_o=1111, addr_o=0, data_o=0, strobes=0, tpm_cycle_o=0, wait counter=0 immediately; mid-cycle reset releases LAD at once.

Structure
REQ-033 State encodings, START/CYCTYPE/SYNC nibble constants SHALL live in shared package lpc_pkg (successor of lpc_defines).
REQ-034 No sub-module; single FSM plus nibble counter and wait counter sized clog2(MAX_WAIT+1).

Verification
REQ-035 IO read 0x0080, ack_i after 3 SYNC clocks, data_i=A5 -> LAD: 0110 x3, 0000, 0101, 1010, 1111, Z; rd_stb_o one pulse.
REQ-036 IO write 0x0080 data 3C, ack_i immediate -> data_o=3C, wr_stb_o one pulse, SYNC 0000, TAR 1111.
REQ-037 TPM read 0xD401 with TPM_EN=1 -> tpm_cycle_o=1, hit; TPM_EN=0 -> IGNORE, lad_oe_o stays 0.
REQ-038 IO read 0x0081 (miss) -> no strobe, lad_oe_o never asserted.
REQ-039 No ack, MAX_WAIT=8 -> 8x 0110 then 1010, data FF.
REQ-040 LFRAME low + 1111 during SYNC, and rst_i during DATA_RD -> lad_oe_o=0 next cycle / immediately, state IDLE.

Source files
------------

// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - shared LPC state encodings, nibble constants and address match helper
package lpc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CYCTYPE,
        ST_ADDR,
        ST_DATA_WR,
        ST_TAR_H,
        ST_SYNC,
        ST_DATA_RD,
        ST_TAR_P,
        ST_IGNORE
    } lpc_state_t;

    localparam logic [3:0] START_IO   = 4'b0000;
    localparam logic [3:0] START_TPM  = 4'b0101;
    localparam logic [3:0] CYC_IO_RD  = 4'b0000;
    localparam logic [3:0] CYC_IO_WR  = 4'b0010;
    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_LWAIT = 4'b0110;
    localparam logic [3:0] SYNC_ERR   = 4'b1010;
    localparam logic [3:0] LAD_IDLE   = 4'b1111;

    function automatic logic addr_hit(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input logic [15:0] mask);
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/lpc_periph_if.sv
// rtl/lpc_periph_if.sv - LPC bus pins plus local request/response signals of the peripheral
interface lpc_periph_if;
    logic        lframe_i;
    logic [3:0]  lad_i;
    logic [3:0]  lad_o;
    logic        lad_oe_o;
    logic [15:0] addr_o;
    logic [7:0]  data_o;
    logic        wr_stb_o;
    logic        rd_stb_o;
    logic        tpm_cycle_o;
    logic [7:0]  data_i;
    logic        ack_i;

    modport slave (
        input  lframe_i, lad_i, data_i, ack_i,
        output lad_o, lad_oe_o, addr_o, data_o, wr_stb_o, rd_stb_o, tpm_cycle_o
    );

    modport master (
        output lframe_i, lad_i, data_i, ack_i,
        input  lad_o, lad_oe_o, addr_o, data_o, wr_stb_o, rd_stb_o, tpm_cycle_o
    );
endinterface

// File: rtl/lpc_periph.sv
// rtl/lpc_periph.sv - LPC IO/TPM-locality target: decodes host cycles, drives SYNC and read data
module lpc_periph
    import lpc_pkg::*;
#(
    parameter logic [15:0] IO_BASE  = 16'h0080,
    parameter logic [15:0] IO_MASK  = 16'hFFFF,
    parameter int          TPM_EN   = 1,
    parameter logic [15:0] TPM_BASE = 16'hD400,
    parameter logic [15:0] TPM_MASK = 16'hF000,
    parameter int          MAX_WAIT = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    lpc_periph_if.slave  bus
);

    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    lpc_state_t  state, nxt_state;
    logic [1:0]  cnt, nxt_cnt;
    logic [WW-1:0] wait_cnt, nxt_wait;
    logic        is_wr, nxt_is_wr;
    logic        err, nxt_err;
    logic        tpm, nxt_tpm;
    logic [15:0] addr, nxt_addr;
    logic [7:0]  wdata, nxt_wdata;
    logic [7:0]  rdata, nxt_rdata;
    logic [3:0]  lad, nxt_lad;
    logic        oe, nxt_oe;
    logic        wr_stb, nxt_wr_stb;
    logic        rd_stb, nxt_rd_stb;

    logic        start_ok;
    logic [15:0] addr_shift;
    logic        addr_ok;
    logic        sync_step;
    logic [7:0]  rd_byte;

    assign start_ok   = (bus.lad_i == START_IO) || ((TPM_EN != 0) && (bus.lad_i == START_TPM));
    assign addr_shift = {addr[11:0], bus.lad_i};
    assign addr_ok    = tpm ? ((TPM_EN != 0) && addr_hit(addr_shift, TPM_BASE, TPM_MASK))
                            : addr_hit(addr_shift, IO_BASE, IO_MASK);
    // ack is sampled on the edge that enters SYNC and on every long-wait edge after it
    assign sync_step  = ((state == ST_TAR_H) && (cnt == 2'd1)) ||
                        ((state == ST_SYNC) && (lad == SYNC_LWAIT));
    assign rd_byte    = err ? 8'hFF : rdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            wait_cnt <= '0;
            is_wr    <= 1'b0;
            err      <= 1'b0;
            tpm      <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            rdata    <= '0;
            lad      <= LAD_IDLE;
            oe       <= 1'b0;
            wr_stb   <= 1'b0;
            rd_stb   <= 1'b0;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            wait_cnt <= nxt_wait;
            is_wr    <= nxt_is_wr;
            err      <= nxt_err;
            tpm      <= nxt_tpm;
            addr     <= nxt_addr;
            wdata    <= nxt_wdata;
            rdata    <= nxt_rdata;
            lad      <= nxt_lad;
            oe       <= nxt_oe;
            wr_stb   <= nxt_wr_stb;
            rd_stb   <= nxt_rd_stb;
        end
    end

    always_comb begin
        nxt_state  = state;
        nxt_cnt    = cnt;
        nxt_wait   = wait_cnt;
        nxt_is_wr  = is_wr;
        nxt_err    = err;
        nxt_tpm    = tpm;
        nxt_addr   = addr;
        nxt_wdata  = wdata;
        nxt_rdata  = rdata;
        nxt_lad    = LAD_IDLE;
        nxt_oe     = 1'b0;
        nxt_wr_stb = 1'b0;
        nxt_rd_stb = 1'b0;

        if (!bus.lframe_i) begin
            if (start_ok) begin
                nxt_state = ST_CYCTYPE;
                nxt_tpm   = (bus.lad_i == START_TPM);
                nxt_cnt   = '0;
                nxt_wait  = '0;
                nxt_err   = 1'b0;
            end else begin
                nxt_state = ST_IDLE;
            end
        end else begin
            case (state)
                ST_CYCTYPE: begin
                    nxt_cnt = '0;
                    if (bus.lad_i == CYC_IO_RD) begin
                        nxt_state = ST_ADDR;
                        nxt_is_wr = 1'b0;
                    end else if (bus.lad_i == CYC_IO_WR) begin
                        nxt_state = ST_ADDR;
                        nxt_is_wr = 1'b1;
                    end else begin
                        nxt_state = ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    nxt_addr = addr_shift;
                    nxt_cnt  = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        nxt_cnt   = '0;
                        nxt_state = !addr_ok ? ST_IGNORE : (is_wr ? ST_DATA_WR : ST_TAR_H);
                    end
                end
                ST_DATA_WR: begin
                    if (cnt == 2'd0) begin
                        nxt_wdata[3:0] = bus.lad_i;
                        nxt_cnt        = 2'd1;
                    end else begin
                        nxt_wdata[7:4] = bus.lad_i;
                        nxt_cnt        = '0;
                        nxt_state      = ST_TAR_H;
                    end
                end
                ST_TAR_H: begin
                    nxt_cnt = 2'd1;
                    if (cnt == 2'd1) begin
                        nxt_state  = ST_SYNC;
                        nxt_cnt    = '0;
                        nxt_wr_stb = is_wr;
                        nxt_rd_stb = !is_wr;
                    end
                end
                ST_SYNC: begin
                    // a ready or error nibble is on the bus: hand over to data or turnaround
                    if (lad != SYNC_LWAIT) begin
                        nxt_oe  = 1'b1;
                        nxt_cnt = '0;
                        if (is_wr) begin
                            nxt_state = ST_TAR_P;
                        end else begin
                            nxt_state = ST_DATA_RD;
                            nxt_lad   = rd_byte[3:0];
                        end
                    end
                end
                ST_DATA_RD: begin
                    nxt_oe = 1'b1;
                    if (cnt == 2'd0) begin
                        nxt_lad = rd_byte[7:4];
                        nxt_cnt = 2'd1;
                    end else begin
                        nxt_cnt   = '0;
                        nxt_state = ST_TAR_P;
                    end
                end
                ST_TAR_P: begin
                    nxt_cnt = 2'd1;
                    if (cnt == 2'd1) begin
                        nxt_cnt   = '0;
                        nxt_state = ST_IDLE;
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                end
                default: nxt_state = ST_IDLE;
            endcase

            if (sync_step) begin
                nxt_oe = 1'b1;
                if (bus.ack_i) begin
                    nxt_lad   = SYNC_READY;
                    nxt_rdata = bus.data_i;
                end else if (wait_cnt == WW'(MAX_WAIT)) begin
                    nxt_lad = SYNC_ERR;
                    nxt_err = 1'b1;
                end else begin
                    nxt_lad  = SYNC_LWAIT;
                    nxt_wait = wait_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.lad_o       = lad;
    assign bus.lad_oe_o    = oe;
    assign bus.addr_o      = addr;
    assign bus.data_o      = wdata;
    assign bus.wr_stb_o    = wr_stb;
    assign bus.rd_stb_o    = rd_stb;
    assign bus.tpm_cycle_o = tpm;

endmodule
